// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester-side and transmitter-side signals around the shared UART TX arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [2*NUM_REQ-1:0] req_parity;
  logic [1:0]           baud_cfg;
  logic [NUM_REQ-1:0]   ack;
  logic                 ack_err;
  logic                 busy;
  logic [2:0]           grant_id;
  logic                 tx_send;
  logic [7:0]           tx_data;
  logic [1:0]           tx_parity_type;
  logic [1:0]           tx_baud_rate;
  logic                 tx_active;
  logic                 tx_done;

  modport master (
    output req, req_data, req_parity, baud_cfg, tx_active, tx_done,
    input  ack, ack_err, busy, grant_id, tx_send, tx_data, tx_parity_type, tx_baud_rate
  );

  modport slave (
    input  req, req_data, req_parity, baud_cfg, tx_active, tx_done,
    output ack, ack_err, busy, grant_id, tx_send, tx_data, tx_parity_type, tx_baud_rate
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that time-shares one UART transmitter among NUM_REQ byte sources,
// sequencing each frame through the transmitter's active/done flags with a timeout abort.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 65535,
  parameter int TW      = 16
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_WAIT_ACT, S_WAIT_DONE, S_ACK, S_ABORT
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [2:0]         grant_q, grant_d;
  logic [7:0]         data_q, data_d;
  logic [1:0]         par_q, par_d;
  logic [1:0]         baud_q, baud_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               ack_err_q, ack_err_d;
  logic               busy_q, busy_d;
  logic               send_q, send_d;
  logic [TW-1:0]      cnt_q, cnt_d;
  logic [1:0]         act_sync_q, done_sync_q;

  logic        act_s, done_s;
  logic [7:0]  req_pad;
  logic [63:0] data_pad;
  logic [15:0] par_pad;
  logic        found, hit, cnt_exp, ack_state;
  logic [2:0]  sel;
  logic [3:0]  cand, idx, ptr_inc;

  assign act_s    = act_sync_q[1];
  assign done_s   = done_sync_q[1];
  assign req_pad  = 8'(bus.req);
  assign data_pad = 64'(bus.req_data);
  assign par_pad  = 16'(bus.req_parity);
  assign cnt_exp  = (cnt_q == TW'(TIMEOUT));
  assign ptr_inc  = {1'b0, grant_q} + 4'd1;

  // First pending request at or after ptr, wrapping past NUM_REQ-1.
  always_comb begin
    found = 1'b0;
    hit   = 1'b0;
    sel   = 3'd0;
    cand  = 4'd0;
    idx   = 4'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand  = {1'b0, ptr_q} + 4'(i);
      idx   = (cand >= 4'(NUM_REQ)) ? (cand - 4'(NUM_REQ)) : cand;
      hit   = !found && req_pad[idx[2:0]];
      sel   = hit ? idx[2:0] : sel;
      found = found | hit;
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    data_d  = data_q;
    par_d   = par_q;
    baud_d  = baud_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        baud_d = bus.baud_cfg;
        if (found) begin
          state_d = S_SEND;
          grant_d = sel;
          data_d  = data_pad[{sel, 3'b000} +: 8];
          par_d   = par_pad[{sel, 1'b0} +: 2];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        cnt_d   = {TW{1'b0}};
        state_d = S_WAIT_ACT;
      end
      S_WAIT_ACT: begin
        if (act_s) begin
          cnt_d   = {TW{1'b0}};
          state_d = S_WAIT_DONE;
        end else if (cnt_exp) begin
          state_d = S_ABORT;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      // Reaching here implies active was already seen, so a lingering done is not mistaken for completion.
      S_WAIT_DONE: begin
        if (!act_s && done_s) begin
          state_d = S_ACK;
        end else if (cnt_exp) begin
          state_d = S_ABORT;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_ACK, S_ABORT: begin
        ptr_d   = (ptr_inc == 4'(NUM_REQ)) ? 3'd0 : ptr_inc[2:0];
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    ack_state = (state_d == S_ACK) || (state_d == S_ABORT);
    busy_d    = (state_d != S_IDLE);
    send_d    = (state_d == S_SEND) || (state_d == S_WAIT_ACT);
    ack_err_d = (state_d == S_ABORT);
    ack_d     = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      ack_d[i] = ack_state && (grant_q == 3'(i));
    end
  end

  // Two-flop synchronisers for the baud-domain transmitter flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_sync_q  <= 2'b00;
      done_sync_q <= 2'b00;
    end else begin
      act_sync_q  <= {act_sync_q[0], bus.tx_active};
      done_sync_q <= {done_sync_q[0], bus.tx_done};
    end
  end

  // State, pointer, latched frame and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= 3'd0;
      grant_q   <= 3'd0;
      data_q    <= 8'd0;
      par_q     <= 2'd0;
      baud_q    <= 2'd0;
      cnt_q     <= {TW{1'b0}};
      ack_q     <= {NUM_REQ{1'b0}};
      ack_err_q <= 1'b0;
      busy_q    <= 1'b0;
      send_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      data_q    <= data_d;
      par_q     <= par_d;
      baud_q    <= baud_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      ack_err_q <= ack_err_d;
      busy_q    <= busy_d;
      send_q    <= send_d;
    end
  end

  assign bus.ack            = ack_q;
  assign bus.ack_err        = ack_err_q;
  assign bus.busy           = busy_q;
  assign bus.grant_id       = grant_q;
  assign bus.tx_send        = send_q;
  assign bus.tx_data        = data_q;
  assign bus.tx_parity_type = par_q;
  assign bus.tx_baud_rate   = baud_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed vector table, mid-frame reset sequence and
// randomized frames checked against a round-robin reference model.
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int TMO = 100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();
  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT(TMO), .TW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int act_delay = 3;
  int act_len   = 12;
  bit never_act = 1'b0;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [7:0]  par;
    logic [1:0]  baud;
    logic [1:0]  baud_mid;
    int          dly;
    int          len;
    bit          nev;
    int          exp_g;
    logic [7:0]  exp_d;
    logic [1:0]  exp_p;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Transmitter stand-in: active rises act_delay cycles after send, falls act_len later with done.
  initial begin
    int phase;
    int cnt;
    phase = 0;
    cnt   = 0;
    bus.tx_active = 1'b0;
    bus.tx_done   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        phase = 0;
        bus.tx_active = 1'b0;
        bus.tx_done   = 1'b0;
      end else begin
        case (phase)
          0: if (bus.tx_send && !never_act) begin
               phase = 1;
               cnt   = 0;
               bus.tx_done = 1'b0;
             end
          1: begin
               cnt++;
               if (cnt >= act_delay) begin
                 bus.tx_active = 1'b1;
                 phase = 2;
                 cnt   = 0;
               end
             end
          default: begin
               cnt++;
               if (cnt >= act_len) begin
                 bus.tx_active = 1'b0;
                 bus.tx_done   = 1'b1;
                 phase = 0;
               end
             end
        endcase
      end
    end
  end

  // One complete frame, starting and ending on an IDLE-cycle negedge.
  task automatic do_frame(input string tag, input logic [3:0] reqv, input logic [31:0] data,
                          input logic [7:0] par, input logic [1:0] baud, input logic [1:0] baud_mid,
                          input int dly, input int len, input bit nev, input int exp_g,
                          input logic [7:0] exp_d, input logic [1:0] exp_p);
    int wait_n;
    int send_n;
    int span;
    bit hold_ok;
    logic [3:0] exp_ack;
    exp_ack = 4'b0001 << exp_g;
    bus.req = reqv;
    bus.req_data = data;
    bus.req_parity = par;
    bus.baud_cfg = baud;
    act_delay = dly;
    act_len = len;
    never_act = nev;
    wait_n = 0;
    do begin
      @(negedge clk);
      wait_n++;
    end while (!bus.busy && wait_n < 8);
    chk({tag, "_grant_latency"}, wait_n, 1);
    chk({tag, "_grant_id"}, bus.grant_id, exp_g);
    chk({tag, "_tx_data"}, bus.tx_data, exp_d);
    chk({tag, "_tx_parity"}, bus.tx_parity_type, exp_p);
    chk({tag, "_tx_baud"}, bus.tx_baud_rate, baud);
    chk({tag, "_tx_send_at_grant"}, bus.tx_send, 1);
    bus.baud_cfg = baud_mid;
    hold_ok = 1'b1;
    send_n = 0;
    span = 0;
    while (bus.ack == 4'b0000 && span < 400) begin
      if (bus.tx_send) send_n++;
      if (bus.tx_data !== exp_d || bus.tx_baud_rate !== baud || bus.grant_id !== 3'(exp_g))
        hold_ok = 1'b0;
      @(negedge clk);
      span++;
    end
    chk({tag, "_ack"}, bus.ack, exp_ack);
    chk({tag, "_ack_err"}, bus.ack_err, nev);
    chk({tag, "_tx_send_at_ack"}, bus.tx_send, 0);
    chk({tag, "_frame_held"}, hold_ok, 1);
    if (nev)
      chk({tag, "_timeout_span_ok"}, (span >= TMO && span <= TMO + 5), 1);
    else
      chk({tag, "_send_until_active_ok"}, (send_n >= dly + 2 && send_n <= dly + 4), 1);
    @(negedge clk);
    chk({tag, "_ack_one_cycle"}, bus.ack, 0);
    chk({tag, "_idle_gap"}, bus.busy, 0);
  endtask

  initial begin
    int ptr_m;
    int g;
    int wcnt;
    bit quiet;
    bit fnd;
    logic [3:0]  rv;
    logic [31:0] rd;
    logic [7:0]  rp;

    tbl[0] = '{4'b1111, 32'h44332211, 8'b11100100, 2'b01, 2'b01, 3, 12, 1'b0, 0, 8'h11, 2'b00};
    tbl[1] = '{4'b1111, 32'h44332211, 8'b11100100, 2'b01, 2'b01, 3, 12, 1'b0, 1, 8'h22, 2'b01};
    tbl[2] = '{4'b1111, 32'h44332211, 8'b11100100, 2'b01, 2'b01, 3, 12, 1'b0, 2, 8'h33, 2'b10};
    tbl[3] = '{4'b1111, 32'h44332211, 8'b11100100, 2'b01, 2'b01, 3, 12, 1'b0, 3, 8'h44, 2'b11};
    tbl[4] = '{4'b1111, 32'h44332211, 8'b11100100, 2'b01, 2'b01, 3, 12, 1'b0, 0, 8'h11, 2'b00};
    tbl[5] = '{4'b0010, 32'h3C7EA511, 8'b00000100, 2'b00, 2'b11, 10, 90, 1'b0, 1, 8'hA5, 2'b01};
    tbl[6] = '{4'b0100, 32'h5AC30FF0, 8'b01111000, 2'b11, 2'b11, 4, 15, 1'b0, 2, 8'hC3, 2'b11};
    tbl[7] = '{4'b0101, 32'h5AC30FF0, 8'b01111000, 2'b11, 2'b11, 2, 9, 1'b0, 0, 8'hF0, 2'b00};
    tbl[8] = '{4'b1000, 32'h5AC30FF0, 8'b01111000, 2'b11, 2'b11, 3, 12, 1'b1, 3, 8'h5A, 2'b01};
    tbl[9] = '{4'b1001, 32'h5AC30FF0, 8'b01111000, 2'b10, 2'b10, 5, 20, 1'b0, 0, 8'hF0, 2'b00};

    rst = 1'b1;
    bus.req = 4'b0000;
    bus.req_data = 32'h0;
    bus.req_parity = 8'h0;
    bus.baud_cfg = 2'b10;
    repeat (3) @(negedge clk);
    chk("rst_ack", bus.ack, 0);
    chk("rst_ack_err", bus.ack_err, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_grant_id", bus.grant_id, 0);
    chk("rst_tx_send", bus.tx_send, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_tx_parity", bus.tx_parity_type, 0);
    chk("rst_tx_baud", bus.tx_baud_rate, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      do_frame($sformatf("vec%0d", i), tbl[i].req, tbl[i].data, tbl[i].par, tbl[i].baud,
               tbl[i].baud_mid, tbl[i].dly, tbl[i].len, tbl[i].nev, tbl[i].exp_g,
               tbl[i].exp_d, tbl[i].exp_p);
    end

    // Reset while the frame for requester 2 sits in WAIT_DONE; pointer is 1 beforehand.
    bus.req = 4'b0100;
    bus.baud_cfg = 2'b01;
    act_delay = 3;
    act_len = 40;
    never_act = 1'b0;
    wcnt = 0;
    do begin
      @(negedge clk);
      wcnt++;
    end while (!bus.tx_send && wcnt < 10);
    wcnt = 0;
    do begin
      @(negedge clk);
      wcnt++;
    end while (bus.tx_send && wcnt < 30);
    repeat (5) @(negedge clk);
    chk("midrst_pre_busy", bus.busy, 1);
    rst = 1'b1;
    bus.req = 4'b1111;
    @(negedge clk);
    chk("midrst_tx_send", bus.tx_send, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_ack", bus.ack, 0);
    chk("midrst_grant_id", bus.grant_id, 0);
    chk("midrst_tx_data", bus.tx_data, 0);
    chk("midrst_tx_baud", bus.tx_baud_rate, 0);
    quiet = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.ack !== 4'b0000 || bus.busy !== 1'b0) quiet = 1'b0;
    end
    chk("midrst_quiet", quiet, 1);
    rst = 1'b0;
    do_frame("postrst", 4'b1111, 32'hD4C3B2A1, 8'b00011011, 2'b01, 2'b01, 3, 10, 1'b0,
             0, 8'hA1, 2'b11);
    ptr_m = 1;

    for (int k = 0; k < 30; k++) begin
      rv = 4'($urandom_range(1, 15));
      rd = $urandom;
      rp = 8'($urandom);
      fnd = 1'b0;
      g = 0;
      for (int i = 0; i < N; i++) begin
        if (!fnd && rv[(ptr_m + i) % N]) begin
          fnd = 1'b1;
          g = (ptr_m + i) % N;
        end
      end
      do_frame($sformatf("rnd%0d", k), rv, rd, rp, 2'($urandom), 2'($urandom),
               $urandom_range(1, 10), $urandom_range(6, 30), ($urandom_range(0, 7) == 0),
               g, rd[8*g +: 8], rp[2*g +: 2]);
      ptr_m = (g + 1) % N;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
